// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin, burst-limited arbiter sharing one storage register among requesters
module reg_write_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rest,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    wdata,
  input  logic                     clr,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  output logic [WIDTH-1:0]         q
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [IW-1:0] ptr, win, nxt;
  logic [BW-1:0] cnt;
  logic found;
  logic [WIDTH-1:0] lane;
  always_comb begin
    win = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        win = IW'((int'(ptr) + k) % NREQ);
        found = 1'b1;
      end
    end
  end
  assign nxt = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign lane = wdata[owner*WIDTH +: WIDTH];
  always_ff @(posedge clk) begin
    if (rest) begin
      state <= IDLE;
      gnt <= '0;
      busy <= 1'b0;
      owner <= '0;
      q <= '0;
      ptr <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      q <= clr ? '0 : q;
      if (found) begin
        state <= GRANT;
        owner <= win;
        gnt <= NREQ'(1) << win;
        busy <= 1'b1;
        cnt <= '0;
      end
    end else begin
      q <= clr ? '0 : (req[owner] ? lane : q);
      cnt <= req[owner] ? cnt + 1'b1 : cnt;
      if (!req[owner] || cnt == BW'(MAX_BURST - 1)) begin
        state <= IDLE;
        gnt <= '0;
        busy <= 1'b0;
        ptr <= nxt;
      end
    end
  end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: scoreboard bench comparing the arbiter against a behavioural model
module tb_reg_write_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic rest = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*WIDTH-1:0] wdata = '0;
  logic clr = 1'b0;
  logic [NREQ-1:0] gnt;
  logic [1:0] owner;
  logic busy;
  logic [WIDTH-1:0] q;
  typedef struct {
    logic [NREQ-1:0] g;
    logic [1:0] o;
    logic b;
    logic [WIDTH-1:0] d;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int passed = 0;
  int m_own = -1;
  int m_last = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  logic [WIDTH-1:0] m_q = '0;
  reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MB)) dut (
    .clk(clk), .rest(rest), .req(req), .wdata(wdata), .clr(clr),
    .gnt(gnt), .owner(owner), .busy(busy), .q(q)
  );
  always #5 clk = ~clk;
  task automatic model(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ*WIDTH-1:0] wd, input logic c);
    exp_t e;
    if (r) begin
      m_own = -1;
      m_last = 0;
      m_ptr = 0;
      m_cnt = 0;
      m_q = '0;
    end else if (m_own < 0) begin
      if (c) m_q = '0;
      for (int k = 0; k < NREQ; k++) begin
        if (m_own < 0 && rq[(m_ptr + k) % NREQ]) begin
          m_own = (m_ptr + k) % NREQ;
          m_last = m_own;
          m_cnt = 0;
        end
      end
    end else begin
      if (rq[m_own]) begin
        m_q = c ? '0 : wd[m_own*WIDTH +: WIDTH];
        m_cnt++;
      end else if (c) m_q = '0;
      if (!rq[m_own] || m_cnt == MB) begin
        m_ptr = (m_own + 1) % NREQ;
        m_own = -1;
      end
    end
    e.g = (m_own < 0) ? '0 : NREQ'(1) << m_own;
    e.o = 2'(m_last);
    e.b = (m_own >= 0);
    e.d = m_q;
    sb.push_back(e);
  endtask
  task automatic step(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ*WIDTH-1:0] wd, input logic c);
    rest = r;
    req = rq;
    wdata = wd;
    clr = c;
    @(posedge clk);
    model(r, rq, wd, c);
    #1;
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (gnt === e.g && owner === e.o && busy === e.b && q === e.d) passed++;
      else $display("FAIL cycle_check t=%0t got gnt=%b owner=%0d busy=%b q=%h want gnt=%b owner=%0d busy=%b q=%h",
                    $time, gnt, owner, busy, q, e.g, e.o, e.b, e.d);
    end
  end
  initial begin
    logic [NREQ-1:0] rr;
    logic [7:0] vals [5];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    @(posedge clk);
    #1;
    step(1, 4'b1111, '0, 0);
    step(1, 4'b1111, '0, 0);
    for (int i = 0; i < 3; i++) step(0, 4'b1111, 32'hA1B2C3D4, 0);
    step(1, '0, '0, 0);
    step(0, 4'b0100, 32'h00110000, 0);
    for (int i = 0; i < 5; i++) step(0, 4'b0100, {8'h00, vals[i], 16'h0000}, 0);
    for (int i = 0; i < 3; i++) step(0, 4'b0100, 32'h00660000, 0);
    step(1, '0, '0, 0);
    for (int i = 0; i < 26; i++) step(0, 4'b1111, {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, 0);
    step(1, '0, '0, 0);
    step(0, 4'b0010, 32'h0000A500, 0);
    step(0, 4'b0010, 32'h0000A500, 0);
    step(0, 4'b1000, 32'h9900A500, 0);
    step(0, 4'b1000, 32'h9900A500, 0);
    step(0, 4'b1000, 32'h9900A500, 0);
    step(1, '0, '0, 0);
    step(0, 4'b0001, 32'h0000007E, 0);
    step(0, 4'b0001, 32'h0000007E, 1);
    step(0, 4'b0001, 32'h0000007E, 0);
    step(0, 4'b0001, 32'h0000007F, 0);
    step(0, 4'b0001, 32'h00000080, 0);
    step(0, 4'b0001, 32'h00000081, 0);
    step(1, '0, '0, 0);
    step(0, 4'b1000, 32'h3C000000, 0);
    step(0, 4'b1000, 32'h3C000000, 0);
    step(1, 4'b1000, 32'h5A000000, 0);
    step(0, 4'b1010, 32'h5A00C300, 0);
    step(0, 4'b1010, 32'h5A00C300, 0);
    rr = '0;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NREQ; k++) if ($urandom_range(0, 99) < 20) rr[k] = ~rr[k];
      step($urandom_range(0, 99) < 2, rr, $urandom, $urandom_range(0, 99) < 10);
    end
    step(0, '0, '0, 0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
